// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: the operand is split into `stages` chunks, one chunk is
// added per stage and the carry is registered between stages, behind valid/ready.
module pipelined_adder #(
  parameter int bits   = 32,
  parameter int stages = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [bits-1:0] a,
  input  logic [bits-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [bits-1:0] s,
  output logic            cout,
  output logic            ovf
);

  localparam int W = bits / stages;

  logic w_en;

  for (genvar k = 0; k < stages; k++) begin : g_stage
    // Operands still to be added shrink by one chunk per stage; results grow by one.
    localparam int OW = (stages - k) * W;

    logic                 w_v_in;
    logic                 w_c_in;
    logic [OW-1:0]        w_a_in;
    logic [OW-1:0]        w_b_in;
    logic [(k+1)*W-1:0]   w_s_nx;
    logic [W:0]           w_chunk;

    logic                 r_vld;
    logic                 r_c;
    logic [(k+1)*W-1:0]   r_s;

    if (k == 0) begin : g_head
      assign w_v_in = in_valid;
      assign w_a_in = a;
      assign w_b_in = b ^ {bits{sub}};
      assign w_c_in = cin ^ sub;
      assign w_s_nx = w_chunk[W-1:0];
    end else begin : g_body
      assign w_v_in = g_stage[k-1].r_vld;
      assign w_a_in = g_stage[k-1].g_fwd.r_a;
      assign w_b_in = g_stage[k-1].g_fwd.r_b;
      assign w_c_in = g_stage[k-1].r_c;
      assign w_s_nx = {w_chunk[W-1:0], g_stage[k-1].r_s};
    end

    assign w_chunk = {1'b0, w_a_in[W-1:0]} + {1'b0, w_b_in[W-1:0]} + {{W{1'b0}}, w_c_in};

    // Stage valid, partial-sum and carry register; data only moves with a live beat
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_s   <= {((k+1)*W){1'b0}};
      end else if (w_en) begin
        r_vld <= w_v_in;
        if (w_v_in) begin
          r_c <= w_chunk[W];
          r_s <= w_s_nx;
        end
      end
    end

    if (k < stages - 1) begin : g_fwd
      logic [OW-W-1:0] r_a;
      logic [OW-W-1:0] r_b;

      // Skew register for the operand chunks that later stages still need
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= {(OW-W){1'b0}};
          r_b <= {(OW-W){1'b0}};
        end else if (w_en && w_v_in) begin
          r_a <= w_a_in[OW-1:W];
          r_b <= w_b_in[OW-1:W];
        end
      end
    end

    if (k == stages - 1) begin : g_tail
      logic r_ovf;

      // Signed overflow is only known once the top chunk has been added
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_en && w_v_in) begin
          r_ovf <= (w_a_in[W-1] ~^ w_b_in[W-1]) & (w_s_nx[bits-1] ^ w_a_in[W-1]);
        end
      end
    end
  end

  assign w_en      = !g_stage[stages-1].r_vld | out_ready;
  assign in_ready  = w_en;
  assign out_valid = g_stage[stages-1].r_vld;
  assign s         = g_stage[stages-1].r_s;
  assign cout      = g_stage[stages-1].r_c;
  assign ovf       = g_stage[stages-1].g_tail.r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: a 32/4 instance plus 8-bit instances with 1, 2 and 8
// stages, all checked every cycle against an arithmetic scoreboard.
module tb_pipelined_adder;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              cin;
  logic              sub;
  logic              out_ready;
  logic [31:0]       a;
  logic [31:0]       b;
  logic [3:0]        dut_ir;
  logic [3:0]        dut_ov;
  logic [3:0]        dut_c;
  logic [3:0]        dut_o;
  logic [3:0][31:0]  dut_s;

  pipelined_adder #(.bits(32), .stages(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_ir[0]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(dut_ov[0]), .out_ready(out_ready),
    .s(dut_s[0]), .cout(dut_c[0]), .ovf(dut_o[0])
  );

  for (genvar g = 1; g < 4; g++) begin : g8
    localparam int ST = (g == 1) ? 1 : ((g == 2) ? 2 : 8);
    logic [7:0] s8;
    pipelined_adder #(.bits(8), .stages(ST)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_ir[g]),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
      .out_valid(dut_ov[g]), .out_ready(out_ready),
      .s(s8), .cout(dut_c[g]), .ovf(dut_o[g])
    );
    assign dut_s[g] = {24'h000000, s8};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int bw_t [4] = '{32, 8, 8, 8};
  int st_t [4] = '{4, 1, 2, 8};

  logic [33:0] exp_q     [4][$];
  int          acc_cyc_q [4][$];
  int          acc_stl_q [4][$];
  int          stall_cnt [4];
  bit          seen      [4];
  bit          prev_ok   [4];
  bit          prev_stall[4];
  logic [33:0] prev_out  [4];

  int          cyc;
  int          n_cmp;
  int          n_fail;
  logic [3:0]  snap_ir;
  logic [3:0]  snap_ov;
  logic [31:0] snap_s0;
  logic        snap_c0;
  logic        snap_o0;

  // Golden result {cout, ovf, s} from plain unsigned and signed integer arithmetic
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic su, input int bw);
    longint full, half, ux, uy, sx, sy, u, sv, c;
    logic   co, ov;
    logic [31:0] r;
    full = longint'(1) << bw;
    half = full / 2;
    ux = longint'(x) & (full - 1);
    uy = longint'(y) & (full - 1);
    sx = (ux >= half) ? ux - full : ux;
    sy = (uy >= half) ? uy - full : uy;
    c  = ci ? 1 : 0;
    if (!su) begin
      u  = ux + uy + c;
      co = (u >= full);
      sv = sx + sy + c;
    end else begin
      u  = ux - uy - c;
      co = (ux >= uy + c);
      sv = sx - sy - c;
    end
    ov = (sv >= half) || (sv < -half);
    r  = 32'(u & (full - 1));
    return {co, ov, r};
  endfunction

  task automatic chk(input string name, input int inst, input logic [33:0] got,
                     input logic [33:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h, expected %h", name, inst, got, want);
    end
  endtask

  task automatic check_cycle();
    logic [33:0] cur, want;
    int lat, dummy;
    for (int i = 0; i < 4; i++) begin
      cur = {dut_c[i], dut_o[i], dut_s[i]};
      if (rst) begin
        exp_q[i].delete();
        acc_cyc_q[i].delete();
        acc_stl_q[i].delete();
        seen[i] = 1'b0;
        prev_ok[i] = 1'b0;
        prev_stall[i] = 1'b0;
      end else begin
        chk("in_ready", i, 34'(dut_ir[i]), 34'(!(dut_ov[i] && !out_ready)));
        if (prev_ok[i] && (prev_stall[i] || !dut_ov[i]))
          chk("output_hold", i, cur, prev_out[i]);
        if (dut_ov[i] && !seen[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("unexpected_out", i, {33'd0, dut_ov[i]}, 34'd0);
          end else begin
            lat = cyc - acc_cyc_q[i][0];
            chk("latency", i, 34'(lat), 34'(st_t[i] + stall_cnt[i] - acc_stl_q[i][0]));
            seen[i] = 1'b1;
          end
        end
        if (dut_ov[i] && out_ready && exp_q[i].size() > 0) begin
          want  = exp_q[i].pop_front();
          dummy = acc_cyc_q[i].pop_front();
          dummy = acc_stl_q[i].pop_front();
          chk("result", i, cur, want);
          seen[i] = 1'b0;
        end
        if (in_valid && dut_ir[i]) begin
          exp_q[i].push_back(model(a, b, cin, sub, bw_t[i]));
          acc_cyc_q[i].push_back(cyc);
          acc_stl_q[i].push_back(stall_cnt[i]);
        end
        prev_stall[i] = dut_ov[i] && !out_ready;
        if (prev_stall[i]) stall_cnt[i]++;
        prev_out[i] = cur;
        prev_ok[i]  = 1'b1;
      end
    end
    snap_ir = dut_ir;
    snap_ov = dut_ov;
    snap_s0 = dut_s[0];
    snap_c0 = dut_c[0];
    snap_o0 = dut_o[0];
    cyc++;
  endtask

  // Sample and check on the falling edge, then return just after the rising edge
  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_and_check(input string name, input logic [31:0] xa, input logic [31:0] xb,
                                input logic xc, input logic xs, input logic [31:0] es,
                                input logic ec, input logic eo);
    int n;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    n = 0;
    do begin step(); n++; end while (!snap_ir[0] && n < 20);
    in_valid = 1'b0;
    n = 0;
    do begin step(); n++; end while (!snap_ov[0] && n < 40);
    chk({name, "_latency"}, 0, 34'(n), 34'd4);
    chk({name, "_s"}, 0, {2'b00, snap_s0}, {2'b00, es});
    chk({name, "_cout"}, 0, {33'd0, snap_c0}, {33'd0, ec});
    chk({name, "_ovf"}, 0, {33'd0, snap_o0}, {33'd0, eo});
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout inst0: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, got, stall_left, n;
    bit stalled, resumed;
    n_cmp = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < 4; i++) begin
      stall_cnt[i] = 0; seen[i] = 1'b0; prev_ok[i] = 1'b0;
      prev_stall[i] = 1'b0; prev_out[i] = 34'd0;
    end
    rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) chk("reset_out_valid", i, {33'd0, snap_ov[i]}, 34'd0);
    chk("reset_s", 0, {2'b00, snap_s0}, 34'd0);
    chk("reset_cout", 0, {33'd0, snap_c0}, 34'd0);
    chk("reset_ovf", 0, {33'd0, snap_o0}, 34'd0);

    chk("model_add_ovf", 0, model(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32), {1'b0, 1'b1, 32'h80000000});
    chk("model_sub8", 1, model(32'h80, 32'h1, 1'b0, 1'b1, 8), {1'b1, 1'b1, 32'h0000007F});

    send_and_check("add_wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    send_and_check("add_ovf",  32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    send_and_check("add_neg",  32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    send_and_check("sub_5_7",  32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    send_and_check("sub_brw",  32'd5, 32'd5, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    send_and_check("sub_ovf",  32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Eight back-to-back beats with a three-cycle consumer stall after the second result
    sent = 0; got = 0; stall_left = 0; stalled = 1'b0; resumed = 1'b0; n = 0;
    out_ready = 1'b1; in_valid = 1'b1; a = 32'd0; b = 32'd0; cin = 1'b0; sub = 1'b0;
    while (got < 8 && n < 200) begin
      step(); n++;
      if (in_valid && snap_ir[0]) sent++;
      if (snap_ov[0] && out_ready) begin
        chk("stream_order", 0, {2'b00, snap_s0}, 34'(32'h11 * got));
        got++;
      end else if (resumed) begin
        chk("stream_gap", 0, {33'd0, snap_ov[0]}, 34'd1);
      end
      if (got == 2 && !stalled) begin stalled = 1'b1; stall_left = 3; end
      if (stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
      end else begin
        out_ready = 1'b1; resumed = stalled;
      end
      in_valid = (sent < 8);
      a = 32'(sent);
      b = 32'(32'h10 * sent);
    end
    chk("stream_count", 0, 34'(got), 34'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) step();

    // Reset with three beats in flight: none of them may emerge
    in_valid = 1'b1; b = 32'd200;
    for (int k = 0; k < 3; k++) begin
      a = 32'(100 + k);
      step();
      chk("pre_reset_accept", 0, {33'd0, snap_ir[0]}, 34'd1);
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("flush_s", 0, {2'b00, snap_s0}, 34'd0);
    chk("flush_cout", 0, {33'd0, snap_c0}, 34'd0);
    chk("flush_ovf", 0, {33'd0, snap_o0}, 34'd0);
    repeat (6) begin
      chk("flush_out_valid", 0, {33'd0, snap_ov[0]}, 34'd0);
      step();
    end
    send_and_check("post_reset", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);

    // Random traffic with random backpressure on all instances
    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) step();
    for (int i = 0; i < 4; i++) chk("drain_empty", i, 34'(exp_q[i].size()), 34'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined successor to the combinational ripple adder. It splits a bits-wide add/subtract into `stages` equal chunks, with one chunk added per pipeline stage and the carry registered between stages. Operands enter and results leave through valid/ready handshakes, with backpressure. It sits in the datapath wherever a wide adder would otherwise limit the clock period.

Parameters:
bits, 32, operand/result width; must satisfy bits % stages == 0.
stages, 4, pipeline depth and chunk count; 1 <= stages <= bits. Chunk width w = bits/stages.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts a beat this cycle
a  input  bits  operand A
b  input  bits  operand B
cin  input  1  carry-in (borrow-in when sub=1)
sub  input  1  0: a+b+cin; 1: a-b-cin
out_valid  output  1  result beat present
out_ready  input  1  consumer accepts result this cycle
s  output  bits  sum/difference
cout  output  1  carry-out of bit bits-1 (raw carry; 0 = borrow when sub=1)
ovf  output  1  signed (two's complement) overflow

Behaviour:
- Reset: clk edge with rst=1 clears every stage valid bit; out_valid=0, s=0, cout=0, ovf=0 the following cycle. In-flight beats are discarded and never emerge. rst overrides all handshake activity in that cycle.
- Effective operands: b_eff = b ^ {bits{sub}}; c0 = cin ^ sub. Result = a + b_eff + c0, truncated to bits; cout is the carry out of the full-width sum.
- Overflow: ovf = (a[bits-1] ~^ b_eff[bits-1]) & (s[bits-1] ^ a[bits-1]).
- Advance: en = !out_valid | out_ready. in_ready = en, combinationally. When en=0, the whole pipeline holds, including valid bits, data and carries.
- Transfers: an input is accepted when in_valid & in_ready. An output is consumed when out_valid & out_ready.
- Stage k (k = 0..stages-1):
  - Adds chunk k of a and b_eff plus the carry from stage k-1 (c0 for k=0) and registers the w-bit partial sum and carry.
  - Operand chunks above k are carried forward in registers (input skew).
  - Result chunks below k are carried forward in registers (output deskew).
  - At the last stage all chunks are aligned.
- Latency: exactly `stages` en-cycles from acceptance to out_valid=1 for that beat. Throughput is one beat per cycle when out_ready is held at 1.
- stages=1: a single registered full-width add with latency 1.
- Ordering: results emerge in acceptance order. There is no loss and no duplication under any out_ready pattern.
- Simultaneous consume and accept in one cycle is allowed. The pipeline shifts by one and out_valid stays 1 if the next beat is ready.
- Output hold: while out_valid=1 and out_ready=0, s, cout and ovf are stable. While out_valid=0, s, cout and ovf hold their last values (0 after reset).
- sub and cin are sampled with the operands at acceptance and travel with the beat.
- No combinational path from a, b or in_valid to the outputs. in_ready depends only on out_valid and out_ready.

Test Plan:
1. bits=32, stages=4: a=0xFFFFFFFF, b=0x1, cin=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, s=0x00000000, cout=1, ovf=0.
2. a=0x7FFFFFFF, b=0x1, cin=0, sub=0 -> s=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 -> s=0, cout=1, ovf=1.
3. Subtract: a=5, b=7, cin=0, sub=1 -> s=0xFFFFFFFE, cout=0, ovf=0. a=5, b=5, cin=1, sub=1 -> s=0xFFFFFFFF, cout=0. a=0x80000000, b=1, sub=1 -> s=0x7FFFFFFF, ovf=1.
4. Stream 8 beats (a=i, b=0x10*i) back to back, and drop out_ready for 3 cycles after the 2nd result -> in_ready=0 exactly while out_valid & !out_ready; all 8 results arrive in order with no gaps once out_ready=1; s stays stable during the stall.
5. Accept 3 beats, then assert rst for 1 cycle with out_ready=1 -> out_valid=0 from the next cycle; none of the 3 results appear; a new beat after reset emerges with latency 4.
6. Parameter sweep: bits=8 with stages=1, 2, 8; 1000 random beats with random sub, cin and out_ready -> every result matches the golden model (a + b_eff + c0, cout, ovf); latency equals stages when unstalled.
